mult_result_buffer: RTL and testbench
=====================================

// Module: mult_result_buffer
// PURPOSE
//   Downstream stage of the simple multiplier: captures each product on the controller's one-cycle done
//   pulse and queues it in a small FIFO. Presents results on a valid/ready stream.
//   Issues issue_ok back to the operand side so a new multiply is launched only when its result has a slot.
//   The multiplier cannot stall in DONE; this block absorbs that.
// PARAMETERS
//   PROD_W  16  product width in bits (2 x operand width)
//   DEPTH    4  FIFO entries; power of 2, >= 2
//   CNT_W   $clog2(DEPTH)+1  occupancy counter width (derived, localparam)
// PORTS
//   clk           in   1       rising-edge clock
//   reset         in   1       synchronous, active-high reset
//   mult_start    in   1       multiply launched this cycle (ld_input while controller ready)
//   mult_done     in   1       controller done pulse, one cycle
//   mult_product  in   PROD_W  product, valid when mult_done=1
//   issue_ok      out  1       1 = room exists for one more in-flight result
//   res_valid     out  1       head entry valid
//   res_data      out  PROD_W  head entry (first-word fall-through)
//   res_ready     in   1       consumer accepts head when res_valid=1
//   count         out  CNT_W   entries currently held
//   overflow      out  1       sticky: a product was dropped
//   proto_err     out  1       sticky: mult_start while in flight, or mult_done with none in flight
// BEHAVIOUR
//   - Reset (all synchronous, highest priority): wr_ptr=rd_ptr=0, count=0, inflight=0.
//     res_valid=0, overflow=0, proto_err=0, issue_ok=1. res_data is don't-care, storage not cleared.
//     Inputs sampled in a reset cycle are ignored.
//   - inflight flag: set on mult_start; cleared on mult_done. Both in one cycle: set wins.
//     That is done for the old op plus start of the new one.
//   - issue_ok = (count + inflight) < DEPTH, combinational from registers only.
//   - push = mult_done & (!full | pop); pop = res_valid & res_ready.
//   - full = (count==DEPTH); empty = (count==0).
//   - push writes mem[wr_ptr] <= mult_product, wr_ptr++. pop rd_ptr++.
//   - Pointers are log2(DEPTH) bits and wrap naturally.
//   - count: +1 push only, -1 pop only, unchanged if both or neither.
//   - Latency: mult_done at edge N -> res_valid=1 and res_data=product after edge N (cycle N+1).
//     There is no bypass into an empty FIFO.
//   - res_valid = !empty. res_data = mem[rd_ptr]. Both are stable while res_valid & !res_ready.
//   - Full with simultaneous mult_done and pop: both proceed, count stays DEPTH, no overflow.
//   - Full with mult_done and no pop: product dropped, overflow<=1 until reset. FIFO contents are untouched.
//   - mult_start while inflight & !mult_done -> proto_err<=1. mult_done while !inflight -> proto_err<=1.
//     In both cases the data path behaves as if the error had not occurred.
//   - Reset mid-operation: queued and in-flight results are discarded. issue_ok=1 the next cycle.
// STRUCTURE
//   - mult_pkg holds: OP_W, PROD_W defaults; typedef enum logic [1:0] {READY, OPERATE, DONE} mult_state_t.
//     The controller and bench use the same package.
//   - One sub-module, sync_fifo #(W, DEPTH): storage, pointers, count, full/empty.
//     It is reusable on the operand side later.
//   - The wrapper holds inflight, issue_ok, the push/drop decision and the sticky flags.
// TESTING
//   1. Reset, idle: after reset -> res_valid=0, count=0, issue_ok=1, overflow=0, proto_err=0.
//   2. Single result: start, done with product 16'h00F0, res_ready=1.
//      -> res_valid high exactly one cycle after done, res_data=16'h00F0, count back to 0.
//   3. Fill, no drain, DEPTH=4: products 1,2,3,4 in sequence.
//      -> count=4, issue_ok=0 once count+inflight=4. Drain yields 1,2,3,4 in order.
//   4. Overflow: full, res_ready=0, force done with 16'hDEAD.
//      -> overflow=1, count=4, drained data is 1,2,3,4 (no DEAD).
//   5. Full with simultaneous done(16'h0055) and pop.
//      -> count stays 4, overflow=0, 16'h0055 appears last. Pointer wrap is checked over >= 3 x DEPTH ops.
//   6. Reset mid-flight: 2 queued + 1 in flight, reset one cycle.
//      -> count=0, res_valid=0, issue_ok=1. A late mult_done after reset with no start -> proto_err=1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the simple multiplier, its controller and the result
// buffer.
//   OP_W, PROD_W  : default operand and product widths
//   BUF_DEPTH     : default result buffer depth
//   mult_state_t  : multiplier controller states
//   cnt_width()   : width of an occupancy counter able to hold 0..depth
package mult_pkg;

  localparam int OP_W      = 8;
  localparam int PROD_W    = 2 * OP_W;
  localparam int BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    READY,
    OPERATE,
    DONE
  } mult_state_t;

  // One extra bit over the pointer width so that "full" (count==depth) is
  // representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push       : write wdata this cycle (caller guarantees !full or pop)
//   pop        : retire the head entry this cycle (caller guarantees !empty)
//   wdata      : write data
//   rdata      : head entry, valid while !empty
//   count      : entries held
//   full/empty : count==DEPTH / count==0
// Storage is not cleared by reset; only pointers and count are.
module sync_fifo
  import mult_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers are exactly log2(DEPTH) bits, so increment wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; gated by reset so a reset cycle leaves contents alone.
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mult_result_buffer.sv
// Result buffer behind the simple multiplier.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   mult_start    : a multiply was launched this cycle
//   mult_done     : one-cycle done pulse from the controller
//   mult_product  : product, valid with mult_done
//   issue_ok      : room exists for one more in-flight result
//   res_valid     : head entry valid
//   res_data      : head entry (first-word fall-through)
//   res_ready     : consumer accepts head when res_valid
//   count         : entries held
//   overflow      : sticky, a product was dropped
//   proto_err     : sticky, start while in flight or done with none in flight
// The controller cannot stall in DONE, so a product arriving with the FIFO
// full and no simultaneous pop is dropped and flagged.
module mult_result_buffer
  import mult_pkg::*;
#(
  parameter  int PROD_W = mult_pkg::PROD_W,
  parameter  int DEPTH  = BUF_DEPTH,
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              mult_done,
  input  logic [PROD_W-1:0] mult_product,
  output logic              issue_ok,
  output logic              res_valid,
  output logic [PROD_W-1:0] res_data,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              proto_err
);

  logic inflight_q, inflight_d;
  logic overflow_q, overflow_d;
  logic proto_err_q, proto_err_d;
  logic push, pop, full, empty;

  sync_fifo #(
    .W     (PROD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (mult_product),
    .rdata (res_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign res_valid = !empty;
  assign pop       = res_valid & res_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = mult_done & (!full | pop);

  always_comb begin
    // Start wins over done: old op completes while the next one launches.
    inflight_d  = inflight_q;
    if (mult_start)     inflight_d = 1'b1;
    else if (mult_done) inflight_d = 1'b0;

    overflow_d  = overflow_q | (mult_done & full & !pop);
    proto_err_d = proto_err_q
                | (mult_start & inflight_q & !mult_done)
                | (mult_done & !inflight_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q  <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      inflight_q  <= inflight_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  // One extra bit so count + inflight cannot wrap.
  assign issue_ok  = ({1'b0, count} + (CNT_W+1)'(inflight_q)) < (CNT_W+1)'(DEPTH);
  assign overflow  = overflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mult_result_buffer.sv
module tb_mult_result_buffer;
  import mult_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset, mult_start, mult_done, res_ready;
  logic [W-1:0]  mult_product;
  logic          issue_ok, res_valid, overflow, proto_err;
  logic [W-1:0]  res_data;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_result_buffer #(.PROD_W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .mult_start   (mult_start),
    .mult_done    (mult_done),
    .mult_product (mult_product),
    .issue_ok     (issue_ok),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .count        (count),
    .overflow     (overflow),
    .proto_err    (proto_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inputs captured at the active edge, model advanced on the following
  // falling edge, then outputs compared.
  logic         s_reset, s_start, s_done, s_ready, s_seen;
  logic [W-1:0] s_prod;
  logic [W-1:0] mq[$];
  bit           m_infl, m_ovf, m_perr, m_ok;

  initial begin
    s_seen = 1'b0;
    m_ok   = 1'b0;
  end

  always @(posedge clk) begin
    s_reset <= reset;
    s_start <= mult_start;
    s_done  <= mult_done;
    s_ready <= res_ready;
    s_prod  <= mult_product;
    s_seen  <= 1'b1;
  end

  task automatic model_step();
    bit do_pop, do_push, was_full;
    if (s_reset) begin
      mq.delete();
      m_infl = 0; m_ovf = 0; m_perr = 0; m_ok = 1;
    end else if (m_ok) begin
      do_pop   = (mq.size() != 0) && s_ready;
      was_full = (mq.size() == DEPTH);
      do_push  = s_done && (!was_full || do_pop);
      if (s_done && was_full && !do_pop) m_ovf = 1;
      if ((s_start && m_infl && !s_done) || (s_done && !m_infl)) m_perr = 1;
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(s_prod);
      if (s_start)     m_infl = 1;
      else if (s_done) m_infl = 0;
    end
  endtask

  always @(negedge clk) begin
    if (s_seen) model_step();
    if (m_ok) begin
      check("m_valid",    32'(res_valid), 32'(mq.size() != 0));
      check("m_count",    32'(count),     32'(mq.size()));
      check("m_issue_ok", 32'(issue_ok),  32'((mq.size() + int'(m_infl)) < DEPTH));
      check("m_overflow", 32'(overflow),  32'(m_ovf));
      check("m_proto",    32'(proto_err), 32'(m_perr));
      if (mq.size() != 0) check("m_data", 32'(res_data), 32'(mq[0]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic st, input logic dn, input logic [W-1:0] p, input logic rdy);
    mult_start = st; mult_done = dn; mult_product = p; res_ready = rdy;
    @(negedge clk);
    mult_start = 0; mult_done = 0; res_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
    $display("txn reset");
  endtask

  task automatic drain_expect(input logic [W-1:0] exp, input string name);
    check({name, "_valid"}, 32'(res_valid), 32'd1);
    check({name, "_data"},  32'(res_data),  32'(exp));
    $display("txn pop data=%04h", res_data);
    cyc(0, 0, '0, 1);
  endtask

  initial begin
    logic [W-1:0] v;
    reset = 1; mult_start = 0; mult_done = 0; res_ready = 0; mult_product = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    // 1: idle after reset
    check("rst_valid",    32'(res_valid), 0);
    check("rst_count",    32'(count),     0);
    check("rst_issue_ok", 32'(issue_ok),  1);
    check("rst_overflow", 32'(overflow),  0);
    check("rst_proto",    32'(proto_err), 0);

    // 2: single result, one cycle latency
    cyc(1, 0, '0, 1);
    check("single_pre_valid", 32'(res_valid), 0);
    cyc(0, 1, 16'h00F0, 1);
    $display("txn done product=00f0");
    check("single_valid", 32'(res_valid), 1);
    check("single_data",  32'(res_data),  32'h00F0);
    cyc(0, 0, '0, 1);
    check("single_count", 32'(count), 0);

    // 3: fill 1..4 without draining
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, 0, '0, 0);
      if (i == DEPTH) check("fill_issue_ok_inflight", 32'(issue_ok), 0);
      cyc(0, 1, W'(i), 0);
      $display("txn done product=%04h", i);
      if (i == DEPTH - 1) check("fill_issue_ok_3", 32'(issue_ok), 1);
    end
    check("fill_count",    32'(count),    4);
    check("fill_issue_ok", 32'(issue_ok), 0);

    // 4: overflow drops DEAD
    cyc(1, 0, '0, 0);
    cyc(0, 1, 16'hDEAD, 0);
    $display("txn done product=dead (full)");
    check("ovf_flag",  32'(overflow), 1);
    check("ovf_count", 32'(count),    4);
    for (int i = 1; i <= DEPTH; i++) drain_expect(W'(i), "ovf_drain");
    check("ovf_empty", 32'(res_valid), 0);

    // 5: full with simultaneous done and pop
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(1, 0, '0, 0);
      cyc(0, 1, W'(i), 0);
    end
    cyc(1, 0, '0, 0);
    cyc(0, 1, 16'h0055, 1);
    $display("txn done product=0055 with pop");
    check("fullpop_count", 32'(count),    4);
    check("fullpop_ovf",   32'(overflow), 0);
    for (int i = 2; i <= DEPTH; i++) drain_expect(W'(i), "fullpop_drain");
    drain_expect(16'h0055, "fullpop_last");
    // wrap: 3 x DEPTH sequential results through the pointers
    for (int i = 0; i < 3 * DEPTH; i++) begin
      v = W'(16'h0A00 + i);
      cyc(1, 0, '0, 0);
      cyc(0, 1, v, 0);
      drain_expect(v, "wrap");
    end

    // 6: reset mid-flight
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, '0, 0);
      cyc(0, 1, W'(16'h0B00 + i), 0);
    end
    cyc(1, 0, '0, 0);
    check("mid_count_pre", 32'(count), 2);
    do_reset();
    check("mid_count",    32'(count),     0);
    check("mid_valid",    32'(res_valid), 0);
    check("mid_issue_ok", 32'(issue_ok),  1);
    cyc(0, 1, 16'h1234, 0);
    $display("txn late done product=1234");
    check("late_proto", 32'(proto_err), 1);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase        = (i / 300) % 4;
      reset        = ($urandom_range(0, 299) == 0);
      mult_start   = ($urandom_range(0, 2) == 0);
      mult_done    = m_infl ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 40) == 0);
      res_ready    = ($urandom_range(0, 3) < phase);
      mult_product = W'($urandom);
      @(negedge clk);
      $display("txn rnd rst=%0d st=%0d dn=%0d rdy=%0d cnt=%0d", reset, mult_start, mult_done, res_ready, count);
    end
    reset = 0; mult_start = 0; mult_done = 0; res_ready = 0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
